// File: rtl/e_mdu_pkg.sv
// Shared encodings, latencies and result payload for the E-stage multiply/divide unit.
package e_mdu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'd6;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_res_t;

  function automatic logic is_md_start(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_calc.sv
// Combinational multiply/divide datapath; valid is low only for a divide by zero.
module e_md_calc
  import e_mdu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output md_res_t           res,
  output logic              valid
);

  logic [2*DATA_W-1:0] sprod;
  logic [2*DATA_W-1:0] uprod;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   q_mag;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  assign sprod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign uprod = {DATA_W'(0), a} * {DATA_W'(0), b};

  // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
  assign a_neg   = (op == MD_DIV) && a[DATA_W-1];
  assign b_neg   = (op == MD_DIV) && b[DATA_W-1];
  assign a_mag   = a_neg ? (~a + DATA_W'(1)) : a;
  assign b_mag   = b_neg ? (~b + DATA_W'(1)) : b;
  assign divisor = (b == '0) ? DATA_W'(1) : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quo     = (a_neg ^ b_neg) ? (~q_mag + DATA_W'(1)) : q_mag;
  assign rem     = a_neg ? (~r_mag + DATA_W'(1)) : r_mag;

  always_comb begin
    res   = '0;
    valid = 1'b1;
    case (op)
      MD_MULT:  res = {sprod[2*DATA_W-1:DATA_W], sprod[DATA_W-1:0]};
      MD_MULTU: res = {uprod[2*DATA_W-1:DATA_W], uprod[DATA_W-1:0]};
      MD_DIV, MD_DIVU: begin
        res.hi = rem;
        res.lo = quo;
        valid  = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: latency counter, pending result and architectural HI/LO.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   md_op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
  logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              busy_q, busy_d;

  md_res_t calc_res;
  logic    calc_valid;

  e_md_calc u_calc (
    .op    (md_op),
    .a     (A),
    .b     (B),
    .res   (calc_res),
    .valid (calc_valid)
  );

  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (cnt_q != '0) begin
      // In flight: new ops are ignored; the last counted edge retires the result.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (is_md_start(md_op)) begin
      pend_hi_d = calc_res.hi;
      pend_lo_d = calc_res.lo;
      pend_wr_d = calc_valid;
      cnt_d     = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                              : CNT_W'(DIV_CYCLES);
    end else if (md_op == MD_MTHI) begin
      hi_d = A;
    end else if (md_op == MD_MTLO) begin
      lo_d = A;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
